// File: rtl/control_unit.sv
// Multi-cycle CPU control unit: Moore FSM sequencing fetch, decode, ALU, memory and branch steps.
// Build option CU_TRAP_EN: opcodes 0xB-0xE enter a sticky TRAP state instead of acting as NOP.
module control_unit #(
    parameter int MEM_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] instr,
    input  logic       zero_flag,
    input  logic       run,
    output logic       ram_rd_en,
    output logic       ram_write_en,
    output logic       addr_sel,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       ir_load,
    output logic       opr_load,
    output logic       reg_write_en,
    output logic       wb_sel,
    output logic       flags_load,
    output logic       halted,
    output logic [1:0] A1,
    output logic [1:0] A2,
    output logic [1:0] A3,
    output logic [2:0] alu_sel
);

    typedef enum logic [3:0] {
        S_FETCH, S_IR_LD, S_DECODE, S_EXEC, S_OP_FETCH, S_OP_LD,
        S_BRANCH, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_HALT
`ifdef CU_TRAP_EN
        , S_TRAP
`endif
    } state_t;

    localparam logic [1:0] LAST = 2'(MEM_LAT - 1);

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       wait_done;
    logic [3:0] op;
    logic [1:0] rd, rs;

    assign op        = instr[7:4];
    assign rd        = instr[3:2];
    assign rs        = instr[1:0];
    assign wait_done = (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counter only advances while a memory wait is still pending, so any state change clears it.
    always_comb begin
        state_d = state_q;
        cnt_d   = 2'd0;
        case (state_q)
            S_FETCH:    if (wait_done) state_d = S_IR_LD;  else cnt_d = cnt_q + 2'd1;
            S_IR_LD:    state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: state_d = S_EXEC;
                    4'h7, 4'h8, 4'h9, 4'hA:             state_d = S_OP_FETCH;
                    4'hF:                               state_d = S_HALT;
`ifdef CU_TRAP_EN
                    4'hB, 4'hC, 4'hD, 4'hE:             state_d = S_TRAP;
`endif
                    default:                            state_d = S_FETCH;
                endcase
            end
            S_EXEC:     state_d = S_FETCH;
            S_OP_FETCH: if (wait_done) state_d = S_OP_LD;  else cnt_d = cnt_q + 2'd1;
            S_OP_LD: begin
                case (op)
                    4'h7:    state_d = S_MEM_RD;
                    4'h8:    state_d = S_MEM_WR;
                    default: state_d = S_BRANCH;
                endcase
            end
            S_BRANCH:   state_d = S_FETCH;
            S_MEM_RD:   if (wait_done) state_d = S_MEM_WB; else cnt_d = cnt_q + 2'd1;
            S_MEM_WB:   state_d = S_FETCH;
            S_MEM_WR:   state_d = S_FETCH;
            S_HALT:     if (run) state_d = S_FETCH;
`ifdef CU_TRAP_EN
            S_TRAP:     state_d = S_TRAP;
`endif
            default:    state_d = S_FETCH;
        endcase
    end

    // Outputs are gated by reset so nothing is driven while rst is held low.
    always_comb begin
        ram_rd_en    = 1'b0;
        ram_write_en = 1'b0;
        addr_sel     = 1'b0;
        pc_inc       = 1'b0;
        pc_load      = 1'b0;
        ir_load      = 1'b0;
        opr_load     = 1'b0;
        reg_write_en = 1'b0;
        wb_sel       = 1'b0;
        flags_load   = 1'b0;
        halted       = 1'b0;
        A1           = 2'd0;
        A2           = 2'd0;
        A3           = 2'd0;
        alu_sel      = 3'd0;
        if (rst) begin
            case (state_q)
                S_FETCH, S_OP_FETCH: ram_rd_en = 1'b1;
                S_IR_LD: begin
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                end
                S_EXEC: begin
                    A1           = rd;
                    A2           = rs;
                    A3           = rd;
                    reg_write_en = 1'b1;
                    flags_load   = 1'b1;
                    alu_sel      = op[2:0] - 3'd1;
                end
                S_OP_LD: begin
                    opr_load = 1'b1;
                    pc_inc   = 1'b1;
                end
                S_BRANCH: pc_load = (op == 4'h9) ? 1'b1 : zero_flag;
                S_MEM_RD: begin
                    ram_rd_en = 1'b1;
                    addr_sel  = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write_en = 1'b1;
                    wb_sel       = 1'b1;
                    A3           = rd;
                end
                S_MEM_WR: begin
                    ram_write_en = 1'b1;
                    addr_sel     = 1'b1;
                    A1           = rd;
                end
                S_HALT: halted = 1'b1;
`ifdef CU_TRAP_EN
                S_TRAP: halted = 1'b1;
`endif
                default: ;
            endcase
        end
    end

endmodule
